pe_mac_sys: RTL and testbench

//  Parametrised systolic processing element for the MHA matrix arrays; successor of the fixed 16-bit PE.

---
 rtl/mha_pkg.sv | 43 ++++
 rtl/fxp_mul_pipe.sv | 76 +++++++
 rtl/pe_mac_sys.sv | 169 ++++++++++++++++
 tb/tb_pe_mac_sys.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mha_pkg.sv
// -----------------------------------------------------------------------------
// mha_pkg
// Shared definitions for the MHA matrix-array processing elements.
//   - Default data-path parameters (Q2.13 at 16 bits, 3-cycle multiplier,
//     4 accumulator guard bits).
//   - Mode encodings for the PE (pass-sum / output-stationary accumulate).
//   - Fixed-point helpers working on a 64-bit signed carrier so that any
//     parametrisation with 2*DW+GUARD+2 <= 64 can share them:
//       round_shr : add half an LSB (round half up), arithmetic shift right.
//       sat_to    : clamp to the signed range of a dw-bit word.
// -----------------------------------------------------------------------------
package mha_pkg;

  localparam int DW_DEF      = 16;
  localparam int FW_DEF      = 13;
  localparam int MUL_LAT_DEF = 3;
  localparam int GUARD_DEF   = 4;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Round half up then drop fw fraction bits.
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] p,
                                                   input int fw);
    return (p + (64'sd1 <<< (fw - 1))) >>> fw;
  endfunction

  // Clamp v into [-(2^(dw-1)), 2^(dw-1)-1].
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fxp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fxp_mul_pipe
// LAT-stage signed fixed-point multiplier with a valid bit per stage and no
// stall input. Stage 0 registers the full 2*DW product; the remaining stages
// only delay it. Rounding (half up) and the FW-bit arithmetic shift are applied
// on the last stage's output, so O_P is the rounded product aligned to the
// operand scaling, LAT cycles after I_VLD was sampled.
// Ports:
//   I_CLK    clock
//   I_RST_N  synchronous active-low reset (clears stage valids)
//   I_CLR    synchronous flush of all stage valids
//   I_VLD    operand pair valid
//   I_A,I_B  signed DW-bit operands
//   O_VLD    last-stage valid
//   O_P      rounded, shifted product, 2*DW-FW+1 bits signed
//   O_BUSY   any stage holds a valid product
// -----------------------------------------------------------------------------
module fxp_mul_pipe
  import mha_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int FW  = FW_DEF,
  parameter int LAT = MUL_LAT_DEF
) (
  input  logic                   I_CLK,
  input  logic                   I_RST_N,
  input  logic                   I_CLR,
  input  logic                   I_VLD,
  input  logic signed [DW-1:0]   I_A,
  input  logic signed [DW-1:0]   I_B,
  output logic                   O_VLD,
  output logic signed [2*DW-FW:0] O_P,
  output logic                   O_BUSY
);

  localparam int PW = 2 * DW - FW + 1;

  logic                   vld_reg  [LAT];
  logic signed [2*DW-1:0] prod_reg [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge I_CLK) begin
          if (!I_RST_N || I_CLR) begin
            vld_reg[gi] <= 1'b0;
          end else begin
            vld_reg[gi] <= I_VLD;
          end
          prod_reg[gi] <= (2 * DW)'(I_A) * (2 * DW)'(I_B);
        end
      end else begin : g_body
        always_ff @(posedge I_CLK) begin
          if (!I_RST_N || I_CLR) begin
            vld_reg[gi] <= 1'b0;
          end else begin
            vld_reg[gi] <= vld_reg[gi-1];
          end
          prod_reg[gi] <= prod_reg[gi-1];
        end
      end
    end
  endgenerate

  always_comb begin
    O_BUSY = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      O_BUSY = O_BUSY | vld_reg[i];
    end
  end

  assign O_VLD = vld_reg[LAT-1];
  assign O_P   = PW'(round_shr(64'(prod_reg[LAT-1]), FW));

endmodule

// File: rtl/pe_mac_sys.sv
// -----------------------------------------------------------------------------
// pe_mac_sys
// Systolic processing element for the MHA matrix arrays. One signed
// fixed-point multiply can be issued every cycle; there is no back-pressure.
//   MODE=0 (pass-sum): O_OUT = narrow(x*w + d), d from the row above.
//   MODE=1 (accumulate): products are summed in a DW+GUARD bit accumulator;
//          the issue tagged I_LAST emits narrow(acc + prod) and restarts at 0.
// Each issue carries its own mode/last/d tag through a delay line matched to
// the multiplier, so modes may be mixed freely issue by issue. X is forwarded
// to the right neighbour one cycle after input.
// Build option: define PE_SAT_EN to make narrow() saturate to the DW-bit
// signed range; without it narrow() keeps the low DW bits (wraps).
// Ports:
//   I_CLK, I_RST_N          clock, synchronous active-low reset
//   I_MODE                  0=pass-sum, 1=accumulate, sampled per issue
//   I_X_VLD, I_X, I_W       issue strobe and operands
//   I_D_VLD, I_D            partial sum from above (MODE=0 only)
//   I_LAST                  MODE=1 issue closes the dot product
//   I_CLR                   flush pipeline and accumulator
//   O_X_VLD, O_X            forwarded operand (0 when invalid)
//   O_OUT_VLD, O_OUT        one-cycle result pulse (O_OUT=0 when invalid)
//   O_BUSY                  any multiplier stage valid or accumulation open
// -----------------------------------------------------------------------------
module pe_mac_sys
  import mha_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int FW      = FW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int GUARD   = GUARD_DEF
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 I_MODE,
  input  logic                 I_X_VLD,
  input  logic signed [DW-1:0] I_X,
  input  logic signed [DW-1:0] I_W,
  input  logic                 I_D_VLD,
  input  logic signed [DW-1:0] I_D,
  input  logic                 I_LAST,
  input  logic                 I_CLR,
  output logic                 O_X_VLD,
  output logic signed [DW-1:0] O_X,
  output logic                 O_OUT_VLD,
  output logic signed [DW-1:0] O_OUT,
  output logic                 O_BUSY
);

  localparam int ACC_W = DW + GUARD;
  localparam int PW    = 2 * DW - FW + 1;

  logic                 p_vld;
  logic signed [PW-1:0] p_prod;
  logic                 pipe_busy;

  logic                 tag_mode_reg [MUL_LAT];
  logic                 tag_last_reg [MUL_LAT];
  logic signed [DW-1:0] tag_d_reg    [MUL_LAT];

  logic signed [ACC_W-1:0] acc_reg;
  logic                    acc_open_reg;

  logic signed [63:0]   sum_next;
  logic signed [DW-1:0] res_next;

  fxp_mul_pipe #(
    .DW  (DW),
    .FW  (FW),
    .LAT (MUL_LAT)
  ) u_mul (
    .I_CLK   (I_CLK),
    .I_RST_N (I_RST_N),
    .I_CLR   (I_CLR),
    .I_VLD   (I_X_VLD),
    .I_A     (I_X),
    .I_B     (I_W),
    .O_VLD   (p_vld),
    .O_P     (p_prod),
    .O_BUSY  (pipe_busy)
  );

  // Tag delay line, aligned with the multiplier stages. Only the multiplier
  // carries valids, so the tags need no flush of their own.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge I_CLK) begin
          if (!I_RST_N) begin
            tag_mode_reg[gi] <= 1'b0;
            tag_last_reg[gi] <= 1'b0;
            tag_d_reg[gi]    <= '0;
          end else begin
            tag_mode_reg[gi] <= I_MODE;
            tag_last_reg[gi] <= I_LAST;
            tag_d_reg[gi]    <= I_D_VLD ? I_D : '0;
          end
        end
      end else begin : g_body
        always_ff @(posedge I_CLK) begin
          if (!I_RST_N) begin
            tag_mode_reg[gi] <= 1'b0;
            tag_last_reg[gi] <= 1'b0;
            tag_d_reg[gi]    <= '0;
          end else begin
            tag_mode_reg[gi] <= tag_mode_reg[gi-1];
            tag_last_reg[gi] <= tag_last_reg[gi-1];
            tag_d_reg[gi]    <= tag_d_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Sum in a 64-bit carrier so neither the pass-sum add nor the final
  // accumulate step can overflow before narrowing.
  always_comb begin
    sum_next = '0;
    res_next = '0;
    if (tag_mode_reg[MUL_LAT-1] == MODE_PASS) begin
      sum_next = 64'(tag_d_reg[MUL_LAT-1]) + 64'(p_prod);
    end else begin
      sum_next = 64'(acc_reg) + 64'(p_prod);
    end
`ifdef PE_SAT_EN
    res_next = DW'(sat_to(sum_next, DW));
`else
    res_next = DW'(sum_next);
`endif
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      O_X_VLD      <= 1'b0;
      O_X          <= '0;
      O_OUT_VLD    <= 1'b0;
      O_OUT        <= '0;
      acc_reg      <= '0;
      acc_open_reg <= 1'b0;
    end else begin
      // Forwarding is independent of flushes.
      O_X_VLD <= I_X_VLD;
      O_X     <= I_X_VLD ? I_X : '0;

      O_OUT_VLD <= 1'b0;
      O_OUT     <= '0;
      if (I_CLR) begin
        acc_reg      <= '0;
        acc_open_reg <= 1'b0;
      end else if (p_vld) begin
        if (tag_mode_reg[MUL_LAT-1] == MODE_PASS) begin
          O_OUT_VLD <= 1'b1;
          O_OUT     <= res_next;
        end else if (tag_last_reg[MUL_LAT-1]) begin
          O_OUT_VLD    <= 1'b1;
          O_OUT        <= res_next;
          acc_reg      <= '0;
          acc_open_reg <= 1'b0;
        end else begin
          acc_reg      <= ACC_W'(sum_next);
          acc_open_reg <= 1'b1;
        end
      end
    end
  end

  assign O_BUSY = pipe_busy | acc_open_reg;

endmodule

// File: tb/tb_pe_mac_sys.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_sys
// Directed bench for pe_mac_sys at default parameters (DW=16, FW=13,
// MUL_LAT=3). Results are captured with their cycle stamp on each falling
// edge and compared against hand-computed values and issue-relative cycles.
// -----------------------------------------------------------------------------
module tb_pe_mac_sys;

  localparam int DW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode, x_vld, d_vld, last, clr;
  logic [DW-1:0] x, w, d;
  logic          o_x_vld, o_out_vld, o_busy;
  logic [DW-1:0] o_x, o_out;

  int cyc    = 0;
  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] res_q[$];
  int            stamp_q[$];

  pe_mac_sys dut (
    .I_CLK     (clk),
    .I_RST_N   (rst_n),
    .I_MODE    (mode),
    .I_X_VLD   (x_vld),
    .I_X       (x),
    .I_W       (w),
    .I_D_VLD   (d_vld),
    .I_D       (d),
    .I_LAST    (last),
    .I_CLR     (clr),
    .O_X_VLD   (o_x_vld),
    .O_X       (o_x),
    .O_OUT_VLD (o_out_vld),
    .O_OUT     (o_out),
    .O_BUSY    (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_out_vld) begin
      res_q.push_back(o_out);
      stamp_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    mode  = 1'b0;
    x_vld = 1'b0;
    x     = '0;
    w     = '0;
    d_vld = 1'b0;
    d     = '0;
    last  = 1'b0;
    clr   = 1'b0;
  endtask

  // Drives one issue for one cycle; stamp is the cycle count at which the
  // result pulse is expected to be seen.
  task automatic issue(input logic m, input logic [DW-1:0] xi, input logic [DW-1:0] wi,
                       input logic dv, input logic [DW-1:0] di, input logic l,
                       output int stamp);
    mode  = m;
    x_vld = 1'b1;
    x     = xi;
    w     = wi;
    d_vld = dv;
    d     = di;
    last  = l;
    clr   = 1'b0;
    stamp = cyc + 1 + LAT;
    @(negedge clk);
  endtask

  task automatic bubble(input int n);
    idle();
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] v, input int st);
    logic [DW-1:0] r;
    int            s;
    if (res_q.size() == 0) begin
      check_val({tag, " present"}, 32'd0, 32'd1);
    end else begin
      r = res_q.pop_front();
      s = stamp_q.pop_front();
      check_val({tag, " value"}, 32'(r), 32'(v));
      check_val({tag, " cycle"}, 32'(s), 32'(st));
    end
  endtask

  task automatic expect_none(input string tag);
    check_val({tag, " extra results"}, 32'(res_q.size()), 32'd0);
    res_q.delete();
    stamp_q.delete();
  endtask

  int st, st2, s4;
  int st_e[8];
  int tmp;

  initial begin
    // Reset with junk on the inputs: reset must dominate.
    idle();
    rst_n = 1'b0;
    x_vld = 1'b1;
    x     = 16'h1234;
    w     = 16'h1000;
    mode  = 1'b1;
    last  = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst o_out_vld", 32'(o_out_vld), 32'd0);
    check_val("rst o_out", 32'(o_out), 32'd0);
    check_val("rst o_x_vld", 32'(o_x_vld), 32'd0);
    check_val("rst o_x", 32'(o_x), 32'd0);
    check_val("rst o_busy", 32'(o_busy), 32'd0);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    res_q.delete();
    stamp_q.delete();

    // A: pass-sum 1.0*0.5 + 0x0800 = 0x1800; x forwarded one cycle later.
    issue(1'b0, 16'h2000, 16'h1000, 1'b1, 16'h0800, 1'b0, st);
    check_val("A o_x_vld", 32'(o_x_vld), 32'd1);
    check_val("A o_x", 32'(o_x), 32'h2000);
    bubble(1);
    check_val("A o_x_vld idle", 32'(o_x_vld), 32'd0);
    check_val("A o_x idle", 32'(o_x), 32'd0);
    bubble(LAT + 2);
    expect_out("A", 16'h1800, st);
    expect_none("A");

    // B: -1.0*0.5 with d invalid (d value must be ignored) = 0xF000.
    issue(1'b0, 16'hE000, 16'h1000, 1'b0, 16'h1234, 1'b0, st);
    bubble(LAT + 2);
    expect_out("B", 16'hF000, st);
    expect_none("B");

    // C: four 0.25 products accumulated, LAST on the fourth -> 1.0.
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b1, s4);
    check_val("C busy", 32'(o_busy), 32'd1);
    bubble(LAT + 2);
    expect_out("C", 16'h2000, s4);
    expect_none("C");
    check_val("C busy done", 32'(o_busy), 32'd0);
    // Accumulator must restart at zero: 1.0*0.5 alone.
    issue(1'b1, 16'h2000, 16'h1000, 1'b0, 16'h0, 1'b1, st);
    bubble(LAT + 2);
    expect_out("C2", 16'h1000, st);
    expect_none("C2");

    // D: 3.0*3.0 = 9.0 overflows Q2.13.
    issue(1'b0, 16'h6000, 16'h6000, 1'b1, 16'h0, 1'b0, st);
    bubble(LAT + 2);
`ifdef PE_SAT_EN
    expect_out("D", 16'h7FFF, st);
`else
    expect_out("D", 16'h2000, st);
`endif
    expect_none("D");

    // G: exact half-LSB products round up (+0.5 -> 1, -0.5 -> 0).
    issue(1'b0, 16'h0001, 16'h1000, 1'b0, 16'h0, 1'b0, st);
    issue(1'b0, 16'hFFFF, 16'h1000, 1'b0, 16'h0, 1'b0, st2);
    bubble(LAT + 2);
    expect_out("G pos", 16'h0001, st);
    expect_out("G neg", 16'h0000, st2);
    expect_none("G");

    // E: back-to-back issues alternating modes; I_D must be ignored in MODE=1.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        issue(1'b0, 16'h2000, 16'((i / 2 + 1) * 256), 1'b1, 16'(i * 16), 1'b0, tmp);
      end else begin
        issue(1'b1, 16'h2000, 16'((i / 2 + 1) * 16), 1'b1, 16'h7777, (i == 7), tmp);
      end
      st_e[i] = tmp;
    end
    bubble(LAT + 2);
    expect_out("E0", 16'h0100, st_e[0]);
    expect_out("E2", 16'h0220, st_e[2]);
    expect_out("E4", 16'h0340, st_e[4]);
    expect_out("E6", 16'h0460, st_e[6]);
    expect_out("E7 acc", 16'h00A0, st_e[7]);
    expect_none("E");

    // F: open accumulation plus two issues in flight, then I_CLR.
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    bubble(LAT + 2);
    check_val("F busy open", 32'(o_busy), 32'd1);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b1, tmp);
    idle();
    clr   = 1'b1;
    x_vld = 1'b1;
    x     = 16'h1111;
    mode  = 1'b1;
    last  = 1'b1;
    @(negedge clk);
    check_val("F o_x during clr", 32'(o_x), 32'h1111);
    bubble(LAT + 2);
    expect_none("F clr");
    check_val("F busy after clr", 32'(o_busy), 32'd0);
    issue(1'b1, 16'h2000, 16'h1000, 1'b0, 16'h0, 1'b1, st);
    bubble(LAT + 2);
    expect_out("F restart", 16'h1000, st);
    expect_none("F");

    // R: same scenario broken by a one-cycle reset.
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    bubble(LAT + 2);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b0, tmp);
    issue(1'b1, 16'h1000, 16'h1000, 1'b0, 16'h0, 1'b1, tmp);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bubble(LAT + 2);
    expect_none("R rst");
    check_val("R busy after rst", 32'(o_busy), 32'd0);
    issue(1'b1, 16'h2000, 16'h1000, 1'b0, 16'h0, 1'b1, st);
    bubble(LAT + 2);
    expect_out("R restart", 16'h1000, st);
    expect_none("R");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
